// File: rtl/tone_sequencer_if.sv
// Note command channel carrying one {note, beats} command per transfer.
// A transfer happens on a rising edge where cmd_valid && cmd_ready; the producer
// holds note/beats stable while valid is high, and ready does not depend on valid.
interface tone_sequencer_if #(
  parameter int DUR_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [4:0]       cmd_note;
  logic [DUR_W-1:0] cmd_beats;

  modport master (output cmd_valid, cmd_note, cmd_beats, input cmd_ready);
  modport slave  (input cmd_valid, cmd_note, cmd_beats, output cmd_ready);
endinterface

// File: rtl/tone_sequencer.sv
// Queued square-wave tone generator: note commands are buffered in a FIFO and
// played back-to-back, each followed by a programmable silent gap.
module tone_sequencer #(
  parameter int CLK_HZ      = 12000000,
  parameter int DEPTH       = 8,
  parameter int DUR_W       = 4,
  parameter int BEAT_CYCLES = 3000000,
  parameter int GAP_CYCLES  = 120000,
  parameter int DIV_W       = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  tone_sequencer_if.slave          cmd,
  input  logic                     stop,
  output logic                     tone_out,
  output logic                     busy,
  output logic [4:0]               cur_note,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     bad_note,
  output logic [1:0]               dbg_state
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int CYC_W = $clog2(BEAT_CYCLES + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

  // Divisors fold to constants; silent codes get 1 so the phase counter just idles.
  function automatic logic [DIV_W-1:0] note_div(input logic [4:0] code);
    longint f;
    case (code)
      5'd1:  f = 26163;  5'd2:  f = 29366;  5'd3:  f = 32963;  5'd4:  f = 34923;
      5'd5:  f = 39200;  5'd6:  f = 44000;  5'd7:  f = 49388;  5'd8:  f = 52325;
      5'd9:  f = 58733;  5'd10: f = 65925;  5'd11: f = 69846;  5'd12: f = 78399;
      5'd13: f = 88000;  5'd14: f = 98777;  5'd15: f = 104650; 5'd16: f = 117466;
      default: f = 0;
    endcase
    if (f == 0) return DIV_W'(1);
    return DIV_W'((longint'(CLK_HZ) * 100) / f);
  endfunction

  state_t state, state_nx;

  logic [4+DUR_W:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [4+DUR_W:0] head;
  logic [4:0]       head_note;
  logic [DUR_W-1:0] head_beats;
  logic             head_valid, full, empty, push, pop;

  logic [DIV_W-1:0] div_lat, phase;
  logic [CYC_W-1:0] cyc_cnt;
  logic [DUR_W-1:0] beats_lat, beat_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             note_ok, beat_end, note_done, gap_done;

  assign full       = (fifo_level == FULL_LVL);
  assign empty      = (fifo_level == '0);
  assign push       = cmd.cmd_valid && !full && !stop;
  assign pop        = (state == S_LOAD) && !stop;
  assign head       = mem[rd_ptr];
  assign head_note  = head[DUR_W +: 5];
  assign head_beats = head[DUR_W-1:0];
  assign head_valid = (head_note >= 5'd1) && (head_note <= 5'd16);

  assign cmd.cmd_ready = !full;
  assign busy          = (state != S_IDLE) || !empty;
  assign dbg_state     = state;

  assign beat_end  = (cyc_cnt == CYC_W'(BEAT_CYCLES - 1));
  assign note_done = (state == S_PLAY) && beat_end && (beat_cnt == beats_lat - DUR_W'(1));
  assign gap_done  = (state == S_GAP) && (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (!empty) state_nx = S_LOAD;
      S_LOAD: state_nx = S_PLAY;
      S_PLAY: if (note_done) state_nx = (GAP_CYCLES > 0) ? S_GAP : (empty ? S_IDLE : S_LOAD);
      S_GAP:  if (gap_done) state_nx = empty ? S_IDLE : S_LOAD;
      default: state_nx = S_IDLE;
    endcase
    if (stop) state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd.cmd_note, cmd.cmd_beats};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      tone_out   <= 1'b0;
      cur_note   <= '0;
      bad_note   <= 1'b0;
      div_lat    <= DIV_W'(1);
      beats_lat  <= DUR_W'(1);
      note_ok    <= 1'b0;
      phase      <= '0;
      cyc_cnt    <= '0;
      beat_cnt   <= '0;
      gap_cnt    <= '0;
    end else begin
      state    <= state_nx;
      bad_note <= 1'b0;
      if (stop) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
        tone_out   <= 1'b0;
        cur_note   <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      fifo_level <= fifo_level + LVL_W'(1);
        else if (pop && !push) fifo_level <= fifo_level - LVL_W'(1);
        tone_out <= (state == S_PLAY) && note_ok && (phase < (div_lat >> 1));
        case (state)
          S_LOAD: begin
            div_lat   <= note_div(head_note);
            beats_lat <= (head_beats == '0) ? DUR_W'(1) : head_beats;
            note_ok   <= head_valid;
            cur_note  <= head_valid ? head_note : 5'd0;
            bad_note  <= (head_note > 5'd16);
            phase     <= '0;
            cyc_cnt   <= '0;
            beat_cnt  <= '0;
            gap_cnt   <= '0;
          end
          S_PLAY: begin
            phase <= (phase == div_lat - DIV_W'(1)) ? '0 : phase + DIV_W'(1);
            if (beat_end) begin
              cyc_cnt  <= '0;
              beat_cnt <= beat_cnt + DUR_W'(1);
            end else begin
              cyc_cnt <= cyc_cnt + CYC_W'(1);
            end
            if (note_done) begin
              cur_note <= '0;
              gap_cnt  <= '0;
            end
          end
          S_GAP:   gap_cnt <= gap_cnt + GAP_W'(1);
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: a timeline model derived from the note table and
// beat/gap lengths predicts tone_out, cur_note, bad_note and busy cycle by cycle.
module tb_tone_sequencer;
  localparam int CLK_HZ = 1200000;
  localparam int DEPTH  = 8;
  localparam int DUR_W  = 4;
  localparam int BEAT   = 10000;
  localparam int GAP    = 100;
  localparam int DIV_W  = 17;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             stop;
  logic             tone_out, busy, bad_note;
  logic [4:0]       cur_note;
  logic [LVL_W-1:0] fifo_level;
  logic [1:0]       dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  int seq_code[$];
  int seq_beats[$];
  logic [4:0] exp_q[$];

  tone_sequencer_if #(.DUR_W(DUR_W)) cmd ();

  tone_sequencer #(
    .CLK_HZ(CLK_HZ), .DEPTH(DEPTH), .DUR_W(DUR_W),
    .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .DIV_W(DIV_W)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .stop(stop), .tone_out(tone_out),
    .busy(busy), .cur_note(cur_note), .fifo_level(fifo_level),
    .bad_note(bad_note), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int freq_of(int code);
    int tab [16];
    tab = '{26163, 29366, 32963, 34923, 39200, 44000, 49388, 52325,
            58733, 65925, 69846, 78399, 88000, 98777, 104650, 117466};
    if (code < 1 || code > 16) return 0;
    return tab[code-1];
  endfunction

  function automatic logic model_tone(int code, int k);
    int n;
    if (freq_of(code) == 0) return 1'b0;
    n = (CLK_HZ * 100) / freq_of(code);
    return ((k % n) < (n / 2));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_cmd();
    cmd.cmd_valid = 1'b0;
    cmd.cmd_note  = '0;
    cmd.cmd_beats = '0;
  endtask

  task automatic flush();
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  // Pushes seq_code/seq_beats on consecutive edges from an idle DUT and checks
  // every cycle until the sequencer has returned to idle.
  task automatic run_sequence(input string name);
    int n, pp, t_end, exp_cur;
    int p[$];
    int len[$];
    int tone_err, cur_err, bad_err, busy_err, seq_err;
    string tone_msg, cur_msg, bad_msg, busy_msg, seq_msg;
    logic exp_tone, exp_bad, exp_busy;
    logic [4:0] exp_head;
    n = seq_code.size();
    pp = 2;
    tone_err = 0; cur_err = 0; bad_err = 0; busy_err = 0; seq_err = 0;
    tone_msg = ""; cur_msg = ""; bad_msg = ""; busy_msg = ""; seq_msg = "";
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      len.push_back(((seq_beats[i] == 0) ? 1 : seq_beats[i]) * BEAT);
      p.push_back(pp);
      pp += len[i] + GAP + 1;
      exp_q.push_back((freq_of(seq_code[i]) != 0) ? 5'(seq_code[i]) : 5'd0);
    end
    t_end = p[n-1] + len[n-1] + GAP;
    for (int t = 0; t <= t_end + 2; t++) begin
      if (t < n) begin
        cmd.cmd_valid = 1'b1;
        cmd.cmd_note  = 5'(seq_code[t]);
        cmd.cmd_beats = DUR_W'(seq_beats[t]);
      end else begin
        idle_cmd();
      end
      @(posedge clk); #1;
      exp_tone = 1'b0; exp_cur = 0; exp_bad = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (t >= p[i] + 1 && t <= p[i] + len[i]) exp_tone = model_tone(seq_code[i], t - p[i] - 1);
        if (t >= p[i] && t < p[i] + len[i]) exp_cur = (freq_of(seq_code[i]) != 0) ? seq_code[i] : 0;
        if (t == p[i]) begin
          exp_bad = (seq_code[i] > 16);
          exp_head = exp_q.pop_front();
          if (cur_note !== exp_head) begin
            if (seq_err == 0) seq_msg = $sformatf("note %0d got %0d expected %0d", i, cur_note, exp_head);
            seq_err++;
          end
        end
      end
      exp_busy = (t < t_end);
      if (tone_out !== exp_tone) begin
        if (tone_err == 0) tone_msg = $sformatf("cycle %0d got %b expected %b", t, tone_out, exp_tone);
        tone_err++;
      end
      if (cur_note !== 5'(exp_cur)) begin
        if (cur_err == 0) cur_msg = $sformatf("cycle %0d got %0d expected %0d", t, cur_note, exp_cur);
        cur_err++;
      end
      if (bad_note !== exp_bad) begin
        if (bad_err == 0) bad_msg = $sformatf("cycle %0d got %b expected %b", t, bad_note, exp_bad);
        bad_err++;
      end
      if (busy !== exp_busy) begin
        if (busy_err == 0) busy_msg = $sformatf("cycle %0d got %b expected %b", t, busy, exp_busy);
        busy_err++;
      end
    end
    n_total++; if (tone_err !== 0) $display("FAIL %s.tone %0d bad cycles, first %s", name, tone_err, tone_msg); else n_pass++;
    n_total++; if (cur_err !== 0) $display("FAIL %s.cur_note %0d bad cycles, first %s", name, cur_err, cur_msg); else n_pass++;
    n_total++; if (bad_err !== 0) $display("FAIL %s.bad_note %0d bad cycles, first %s", name, bad_err, bad_msg); else n_pass++;
    n_total++; if (busy_err !== 0) $display("FAIL %s.busy %0d bad cycles, first %s", name, busy_err, busy_msg); else n_pass++;
    n_total++; if (seq_err !== 0 || exp_q.size() != 0) $display("FAIL %s.note_order %0d wrong, %0d unplayed, %s", name, seq_err, exp_q.size(), seq_msg); else n_pass++;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1; stop = 1'b0; idle_cmd();
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (tone_out !== 1'b0) $display("FAIL reset.tone_out got %b expected 0", tone_out); else n_pass++;
    n_total++; if (cmd.cmd_ready !== 1'b1) $display("FAIL reset.cmd_ready got %b expected 1", cmd.cmd_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset.busy got %b expected 0", busy); else n_pass++;
    n_total++; if (cur_note !== 5'd0) $display("FAIL reset.cur_note got %0d expected 0", cur_note); else n_pass++;
    n_total++; if (fifo_level !== '0) $display("FAIL reset.fifo_level got %0d expected 0", fifo_level); else n_pass++;
    n_total++; if (bad_note !== 1'b0) $display("FAIL reset.bad_note got %b expected 0", bad_note); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_note();
    seq_code = '{6};
    seq_beats = '{2};
    run_sequence("single_a4");
  endtask

  task automatic test_rest_invalid();
    seq_code = '{1, 0, 20};
    seq_beats = '{1, 1, 1};
    run_sequence("rest_invalid");
  endtask

  task automatic test_zero_beats();
    seq_code = '{int'($urandom_range(1, 16))};
    seq_beats = '{0};
    run_sequence("zero_beats");
  endtask

  task automatic test_random();
    seq_code = '{int'($urandom_range(0, 31)), int'($urandom_range(0, 31))};
    seq_beats = '{int'($urandom_range(0, 1)), int'($urandom_range(0, 1))};
    run_sequence("random");
  endtask

  task automatic test_back_to_back();
    int exp_level = 0;
    cmd.cmd_valid = 1'b1; cmd.cmd_note = 5'd3; cmd.cmd_beats = DUR_W'(15);
    @(posedge clk); #1;
    idle_cmd();
    repeat (2) begin @(posedge clk); #1; end
    for (int j = 0; j <= DEPTH; j++) begin
      cmd.cmd_valid = 1'b1;
      cmd.cmd_note  = 5'($urandom_range(0, 31));
      cmd.cmd_beats = DUR_W'($urandom_range(0, 15));
      n_total++;
      if (cmd.cmd_ready !== (exp_level < DEPTH)) $display("FAIL b2b.ready push %0d got %b expected %b", j, cmd.cmd_ready, exp_level < DEPTH);
      else n_pass++;
      @(posedge clk); #1;
      if (exp_level < DEPTH) exp_level++;
      n_total++;
      if (fifo_level !== LVL_W'(exp_level)) $display("FAIL b2b.level push %0d got %0d expected %0d", j, fifo_level, exp_level);
      else n_pass++;
    end
    idle_cmd();
    @(posedge clk); #1;
    n_total++; if (fifo_level !== LVL_W'(DEPTH)) $display("FAIL b2b.final_level got %0d expected %0d", fifo_level, DEPTH); else n_pass++;
    n_total++; if (cmd.cmd_ready !== 1'b0) $display("FAIL b2b.final_ready got %b expected 0", cmd.cmd_ready); else n_pass++;
    flush();
    n_total++; if (fifo_level !== '0 || busy !== 1'b0) $display("FAIL b2b.flush level %0d busy %b expected 0 0", fifo_level, busy); else n_pass++;
  endtask

  task automatic test_stop();
    int exp_level = 0;
    for (int j = 0; j < 4; j++) begin
      cmd.cmd_valid = 1'b1;
      cmd.cmd_note  = (j == 0) ? 5'd8 : 5'($urandom_range(1, 16));
      cmd.cmd_beats = (j == 0) ? DUR_W'(15) : DUR_W'($urandom_range(0, 15));
      @(posedge clk); #1;
      exp_level++;
      if (j == 2) exp_level--;
    end
    idle_cmd();
    repeat (20) begin @(posedge clk); #1; end
    n_total++; if (tone_out !== 1'b1) $display("FAIL stop.pre_tone got %b expected 1", tone_out); else n_pass++;
    n_total++; if (fifo_level !== LVL_W'(exp_level)) $display("FAIL stop.pre_level got %0d expected %0d", fifo_level, exp_level); else n_pass++;
    cmd.cmd_valid = 1'b1; cmd.cmd_note = 5'd5; cmd.cmd_beats = DUR_W'(1);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    idle_cmd();
    n_total++; if (tone_out !== 1'b0) $display("FAIL stop.tone got %b expected 0", tone_out); else n_pass++;
    n_total++; if (fifo_level !== '0) $display("FAIL stop.level got %0d expected 0", fifo_level); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL stop.busy got %b expected 0", busy); else n_pass++;
    n_total++; if (cur_note !== 5'd0) $display("FAIL stop.cur_note got %0d expected 0", cur_note); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (fifo_level !== '0 || busy !== 1'b0) $display("FAIL stop.dropped_push level %0d busy %b expected 0 0", fifo_level, busy); else n_pass++;
  endtask

  task automatic test_async_reset();
    cmd.cmd_valid = 1'b1; cmd.cmd_note = 5'd6; cmd.cmd_beats = DUR_W'(1);
    @(posedge clk); #1;
    idle_cmd();
    repeat (12) begin @(posedge clk); #1; end
    n_total++; if (tone_out !== 1'b1 || busy !== 1'b1) $display("FAIL areset.pre tone %b busy %b expected 1 1", tone_out, busy); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if (tone_out !== 1'b0) $display("FAIL areset.tone_out got %b expected 0", tone_out); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL areset.busy got %b expected 0", busy); else n_pass++;
    n_total++; if (cur_note !== 5'd0) $display("FAIL areset.cur_note got %0d expected 0", cur_note); else n_pass++;
    n_total++; if (fifo_level !== '0 || cmd.cmd_ready !== 1'b1 || bad_note !== 1'b0)
      $display("FAIL areset.misc level %0d ready %b bad %b expected 0 1 0", fifo_level, cmd.cmd_ready, bad_note);
    else n_pass++;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    cmd.cmd_valid = 1'b1; cmd.cmd_note = 5'd6; cmd.cmd_beats = DUR_W'(1);
    @(posedge clk); #1;
    idle_cmd();
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      n_total++;
      if (tone_out !== (e == 3)) $display("FAIL areset.replay E%0d tone got %b expected %b", e, tone_out, e == 3);
      else n_pass++;
    end
    flush();
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_back_to_back();
    test_stop();
    test_async_reset();
    test_rest_invalid();
    test_zero_beats();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Queued multi-note square-wave tone generator for the buzzer output, generalising the single-note fixed-divider beeper. Software or game logic pushes note commands (note code + duration in beats) into an internal FIFO over a valid/ready handshake. The block plays them back-to-back with a programmable inter-note gap, so melodies play without cycle-level supervision. The clock frequency, FIFO depth, beat length and gap are parameters; the note divisors are derived from `CLK_HZ` at elaboration.

## Interface
- `CLK_HZ`, 12000000: input clock frequency in Hz.
- `DEPTH`, 8: FIFO entries; must be a power of 2, ≥2.
- `DUR_W`, 4: width of the beat-count field.
- `BEAT_CYCLES`, 3000000: clock cycles per beat; must be ≥1.
- `GAP_CYCLES`, 120000: silent cycles after each note; 0 means no gap.
- `DIV_W`, 17: divisor/phase counter width; must hold `CLK_HZ*100/26163`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO not full; equals `!full`.
- `cmd_note`  in  5  0 = rest, 1..16 = notes, 17..31 = invalid.
- `cmd_beats`  in  `DUR_W`  duration in beats; 0 is played as 1 beat.
- `stop`  in  1  synchronous flush: abort the current note and empty the FIFO.
- `tone_out`  out  1  registered square wave to the buzzer.
- `busy`  out  1  FSM not IDLE, or FIFO non-empty.
- `cur_note`  out  5  code of the note being played; 0 otherwise.
- `fifo_level`  out  `$clog2(DEPTH)+1`  occupied FIFO entries.
- `bad_note`  out  1  one-cycle pulse when an invalid code is popped.

## Operation
- Note table, codes 1..16, frequencies in centi-Hz: 26163, 29366, 32963, 34923, 39200, 44000, 49388, 52325, 58733, 65925, 69846, 78399, 88000, 98777, 104650, 117466 (C4..D6, major scale).
- Divisor: `N = (CLK_HZ*100)/freq_centi`, truncated, computed as localparams. The high half-period is `N>>1` cycles.
- Handshake: a push occurs on a rising edge where `cmd_valid && cmd_ready && !stop`. A push while full cannot occur, because `cmd_ready` is 0.
- FSM states: IDLE, LOAD, PLAY, GAP.
  - IDLE: if the FIFO is non-empty, go to LOAD.
  - LOAD: pop one entry; latch the divisor, the beat count (0 becomes 1) and `cur_note`. Clear the phase, cycle and beat counters. Go to PLAY.
  - PLAY: the phase counter counts 0..N-1 and wraps. The cycle counter counts 0..`BEAT_CYCLES`-1; at wrap the beat counter increments. When the last beat's final cycle completes, go to GAP if `GAP_CYCLES`>0, otherwise go to LOAD if the FIFO is non-empty, or IDLE if it is empty.
  - GAP: count `GAP_CYCLES` cycles with the tone low, then go to LOAD if the FIFO is non-empty, or IDLE if it is empty.
- `tone_out` is registered. On the next edge it takes the value `(phase < N>>1)` while in PLAY with a valid note, and 0 otherwise.
- Rest (code 0) and invalid codes 17..31 play silence for the full duration. For invalid codes, `bad_note` pulses for the cycle after LOAD, and `cur_note` reports 0.
- `stop` has priority over every other event. On the next edge: FIFO pointers cleared, FSM to IDLE, `tone_out`=0, `cur_note`=0. A push in the same cycle is dropped.
- Push and pop in the same cycle are both performed, and `fifo_level` is unchanged.

## Timing
- Reset values: `tone_out`=0, `cmd_ready`=1, `busy`=0, `cur_note`=0, `fifo_level`=0, `bad_note`=0, FSM in IDLE, FIFO empty. Reset may assert mid-note; the outputs clear immediately and asynchronously.
- Latency from idle: push on edge E0; IDLE→LOAD at E1; LOAD→PLAY at E2; `tone_out` rises at E3.
- Each note occupies exactly `beats*BEAT_CYCLES` PLAY cycles, then `GAP_CYCLES` GAP cycles, then 1 LOAD cycle for the next queued note.
- The phase restarts at 0 on every LOAD, so every note begins with a high half-period.
- `fifo_level` updates on the edge of each push or pop. `cmd_ready` drops on the edge at which `fifo_level` reaches `DEPTH`.
- `busy` falls on the edge where the FSM enters IDLE with the FIFO empty.

## Test plan
- `CLK_HZ`=1200000, `BEAT_CYCLES`=10000, `GAP_CYCLES`=100. Push note 6 (A4), beats=2 → `N`=2727. `tone_out` rises 3 cycles after the push, stays high for 1363 cycles, then low for 1364. The note lasts 20000 cycles, followed by 100 low cycles, then `busy`=0.
- Push DEPTH+1 commands back-to-back with the FSM held by a long first note → `cmd_ready`=0 after DEPTH pushes, the extra command is not accepted, and `fifo_level`=DEPTH.
- Queue notes 1, 0, 20 with 1 beat each → a tone with `N`=4586, then 10000 silent cycles, then 10000 silent cycles. `bad_note` pulses once, during the third note, and `cur_note` sequence is 1, 0, 0.
- Assert `stop` mid-note with 3 entries queued and `cmd_valid`=1 → on the next edge `tone_out`=0, `fifo_level`=0, IDLE, `busy`=0, and the concurrent push is dropped.
- Assert `rst` asynchronously mid-PLAY → all outputs reach their reset values before the next edge. After release, the first push replays with E3 latency.
- Set `cmd_beats`=0 → the note plays for exactly `BEAT_CYCLES` cycles.
